// File: rtl/axis_tx_mac_queue.sv
// axis_tx_mac_queue
//   Store-and-forward AXI4-Stream to byte-wide MAC TX converter. Whole frames
//   are buffered before release, then serialised lane 0 first onto the
//   tx_data / tx_data_valid / tx_ack handshake, followed by a fixed idle gap.
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   tdata/tstrb/tvalid/tlast   AXI-Stream slave; tstrb qualifies the tlast beat
//   tready                     beat accepted on tvalid & tready
//   tx_data, tx_data_valid     MAC byte stream; byte 0 held until tx_ack
//   tx_ack                     MAC accepts byte 0 of a frame
//   pkts_queued                complete frames buffered and not yet started
//   frame_done                 pulse alongside the last byte of a frame
//   oversize_drop              pulse after the tlast beat of a discarded frame
module axis_tx_mac_queue #(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH_WORDS = 512,
  parameter int MAX_PKTS         = 16,
  parameter int IFG_CYCLES       = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI_DATA_WIDTH-1:0]     tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   tstrb,
  input  logic                          tvalid,
  input  logic                          tlast,
  output logic                          tready,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_ack,
  output logic [$clog2(MAX_PKTS):0]     pkts_queued,
  output logic                          frame_done,
  output logic                          oversize_drop
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH_WORDS);
  localparam int PW    = $clog2(MAX_PKTS) + 1;

  typedef struct packed {
    logic                      last;
    logic [CW-1:0]             cnt;
    logic [AXI_DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, IFG} state_t;

  beat_t         mem [FIFO_DEPTH_WORDS];
  beat_t         wr_beat, rd_beat;
  logic [AW:0]   wr_ptr, rd_ptr, frm_start, used, frm_fill;
  logic [PW:0]   pkts_pend;
  logic [CW-1:0] last_cnt, lane;
  logic [7:0]    ifg_cnt;
  logic          drop, commit_pend, accept, fifo_full, deq, consume, beat_end;
  state_t        state, nxt;

  // ---------------- write side ----------------
  assign used      = wr_ptr - rd_ptr;
  assign frm_fill  = wr_ptr - frm_start;
  assign fifo_full = (used == (AW+1)'(FIFO_DEPTH_WORDS));
  // A frame committed last cycle is not yet in pkts_queued; count it here so
  // the frame limit cannot be overrun by one.
  assign pkts_pend = {1'b0, pkts_queued} + {{PW{1'b0}}, commit_pend};
  assign tready    = ~reset & (drop | (~fifo_full & (pkts_pend < (PW+1)'(MAX_PKTS))));
  assign accept    = tvalid & tready;

  // Byte count of the tlast beat: highest set strobe + 1, at least one byte.
  always_comb begin
    last_cnt = CW'(1);
    for (int i = 0; i < BYTES; i++)
      if (tstrb[i]) last_cnt = CW'(i + 1);
  end

  always_comb begin
    wr_beat.last = tlast;
    wr_beat.cnt  = tlast ? last_cnt : CW'(BYTES);
    wr_beat.data = tdata;
  end

  always_ff @(posedge clk)
    if (accept & ~drop) mem[wr_ptr[AW-1:0]] <= wr_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      frm_start     <= '0;
      drop          <= 1'b0;
      commit_pend   <= 1'b0;
      oversize_drop <= 1'b0;
    end else begin
      commit_pend   <= accept & tlast & ~drop;
      oversize_drop <= accept & tlast & drop;
      if (accept) begin
        if (drop) begin
          if (tlast) drop <= 1'b0;
        end else if (tlast) begin
          wr_ptr    <= wr_ptr + 1'b1;
          frm_start <= wr_ptr + 1'b1;
        end else if (frm_fill == (AW+1)'(FIFO_DEPTH_WORDS - 1)) begin
          // This beat would fill the whole buffer with one unfinished frame:
          // it can never be released, so rewind and swallow the rest.
          drop   <= 1'b1;
          wr_ptr <= frm_start;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Frame is counted one cycle after its tlast beat is written.
  always_ff @(posedge clk) begin
    if (reset) pkts_queued <= '0;
    else begin
      case ({commit_pend, deq})
        2'b10:   pkts_queued <= pkts_queued + PW'(1);
        2'b01:   pkts_queued <= pkts_queued - PW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- read side ----------------
  assign rd_beat  = mem[rd_ptr[AW-1:0]];
  assign deq      = (state == IDLE) & (pkts_queued != '0);
  assign consume  = ((state == WAIT_ACK) & tx_ack) | (state == SEND);
  assign beat_end = consume & ((lane + CW'(1)) == rd_beat.cnt);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (pkts_queued != '0) nxt = WAIT_ACK;
      WAIT_ACK: if (tx_ack) nxt = (beat_end & rd_beat.last) ? IFG : SEND;
      SEND:     if (beat_end & rd_beat.last) nxt = IFG;
      IFG:      if (ifg_cnt == 8'd1) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // ifg_cnt is preloaded outside IFG so the gap is exactly IFG_CYCLES long.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      lane    <= '0;
      ifg_cnt <= '0;
    end else begin
      if (consume) begin
        if (beat_end) begin
          rd_ptr <= rd_ptr + 1'b1;
          lane   <= '0;
        end else begin
          lane <= lane + CW'(1);
        end
      end
      if (state != IFG) ifg_cnt <= 8'(IFG_CYCLES);
      else              ifg_cnt <= ifg_cnt - 8'd1;
    end
  end

  always_comb begin
    tx_data_valid = 1'b0;
    tx_data       = 8'h00;
    frame_done    = beat_end & rd_beat.last;
    if (state == WAIT_ACK || state == SEND) begin
      tx_data_valid = 1'b1;
      tx_data       = rd_beat.data[int'(lane)*8 +: 8];
    end
  end
endmodule

// File: tb/tb_axis_tx_mac_queue.sv
// Directed bench for axis_tx_mac_queue (32-bit stream, 16-word buffer,
// 4-frame limit, 12-cycle gap). A negedge monitor acts as the MAC and
// collects consumed bytes, frame_done pulses, drops and idle-gap lengths.
module tb_axis_tx_mac_queue;
  localparam int DW = 32, DEPTH = 16, MAXP = 4, IFG = 12;

  logic          clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic [3:0]    tstrb = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tready;
  logic [7:0]    tx_data;
  logic          tx_data_valid, tx_ack = 1'b0;
  logic [2:0]    pkts_queued;
  logic          frame_done, oversize_drop;

  axis_tx_mac_queue #(.AXI_DATA_WIDTH(DW), .FIFO_DEPTH_WORDS(DEPTH),
                      .MAX_PKTS(MAXP), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .reset(reset), .tdata(tdata), .tstrb(tstrb), .tvalid(tvalid),
    .tlast(tlast), .tready(tready), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_ack(tx_ack), .pkts_queued(pkts_queued),
    .frame_done(frame_done), .oversize_drop(oversize_drop));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ack_mode = 0;   // 0 low, 1 held high, 2 one cycle after tx_data_valid
  logic v_d = 1'b0;

  logic [7:0] byte_q[$];
  int gap_q[$];
  int done_cnt = 0, drop_cnt = 0, low_run = 0;
  bit acked = 1'b0;

  always @(negedge clk) begin
    v_d = tx_data_valid;
    if (reset) begin
      acked = 1'b0; low_run = 0;
    end else begin
      if (tx_data_valid && (acked || tx_ack)) begin
        byte_q.push_back(tx_data);
        acked = 1'b1;
        if (frame_done) begin acked = 1'b0; done_cnt++; end
      end
      if (oversize_drop) drop_cnt++;
      if (!tx_data_valid) low_run++;
      else if (low_run > 0) begin gap_q.push_back(low_run); low_run = 0; end
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ack = (ack_mode == 1) || (ack_mode == 2 && v_d);
  end

  // Beat b lane l carries base + 4*b + l. Called just after a rising edge.
  task automatic send_frame(input int nbeats, input logic [7:0] base, input logic [3:0] lstrb);
    bit acc; int n;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < 4; l++) tdata[8*l +: 8] = base + 8'(b*4 + l);
      tlast  = (b == nbeats - 1);
      tstrb  = tlast ? lstrb : 4'h0;
      tvalid = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 300) begin
        @(negedge clk); acc = tready; @(posedge clk); n++;
      end
      checks++;
      if (!acc) begin errors++; $display("FAIL send_accept beat %0d: tready=0, required 1 within 300 cycles", b); end
      #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_frames(input int target, output int peak);
    int n = 0;
    peak = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk); n++;
      if (int'(pkts_queued) > peak) peak = int'(pkts_queued);
    end
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL wait_frames: frame_done count %0d, required %0d", done_cnt, target); end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (tx_data_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL %s: tx_data_valid=%b, required 1 within 100 cycles", tag, tx_data_valid); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", tready); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_data_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    checks++; if (pkts_queued !== 3'd0) begin errors++; $display("FAIL reset_pkts: got %0d want 0", pkts_queued); end
    checks++; if (frame_done !== 1'b0 || oversize_drop !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", frame_done, oversize_drop); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %b want 1", tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame;
    int s, d0, n, bad, pk;
    ack_mode = 2; s = byte_q.size(); d0 = done_cnt;
    send_frame(16, 8'h10, 4'hF);
    @(negedge clk); @(negedge clk);
    checks++; if (pkts_queued !== 3'd1) begin errors++; $display("FAIL latency_pkts: got %0d want 1", pkts_queued); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL latency_valid_early: got %b want 0", tx_data_valid); end
    @(negedge clk);
    checks++; if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1", tx_data_valid); end
    checks++; if (tx_data !== 8'h10) begin errors++; $display("FAIL latency_byte0: got %h want 10", tx_data); end
    wait_frames(d0 + 1, pk);
    checks++; if (pkts_queued !== 3'd0) begin errors++; $display("FAIL single_pkts_after: got %0d want 0", pkts_queued); end
    repeat (20) @(negedge clk);
    n = byte_q.size() - s;
    checks++; if (n != 64) begin errors++; $display("FAIL single_len: got %0d want 64", n); end
    bad = 0;
    for (int i = 0; i < n && i < 64; i++) if (byte_q[s+i] !== 8'h10 + 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_data: %0d wrong bytes, want 0", bad); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_once: got %0d want 1", done_cnt - d0); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_last;
    int s, d0, n, bad, pk;
    ack_mode = 2; s = byte_q.size(); d0 = done_cnt;
    send_frame(16, 8'h80, 4'h1);
    wait_frames(d0 + 1, pk);
    n = byte_q.size() - s;
    checks++; if (n != 61) begin errors++; $display("FAIL partial_len: got %0d want 61", n); end
    bad = 0;
    for (int i = 0; i < n && i < 61; i++) if (byte_q[s+i] !== 8'h80 + 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL partial_data: %0d wrong bytes, want 0", bad); end
    checks++; if (n >= 61 && byte_q[s+60] !== 8'hBC) begin errors++; $display("FAIL partial_last_byte: got %h want bc", byte_q[s+60]); end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // tstrb=0 still carries one byte; a strobe hole is sent as if set.
  task automatic test_strb_edges;
    int s, d0, n, pk;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA0; exp_b[1] = 8'hB0; exp_b[2] = 8'hB1; exp_b[3] = 8'hB2;
    ack_mode = 2; s = byte_q.size(); d0 = done_cnt;
    send_frame(1, 8'hA0, 4'h0);
    send_frame(1, 8'hB0, 4'b0101);
    wait_frames(d0 + 2, pk);
    n = byte_q.size() - s;
    checks++; if (n != 4) begin errors++; $display("FAIL strb_len: got %0d want 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++;
      if (byte_q[s+i] !== exp_b[i]) begin errors++; $display("FAIL strb_byte%0d: got %h want %h", i, byte_q[s+i], exp_b[i]); end
    end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int s, d0, g0, n, bad, pk;
    logic [7:0] e;
    ack_mode = 1; s = byte_q.size(); d0 = done_cnt;
    send_frame(2, 8'h20, 4'hF);
    wait_valid("b2b_first_valid");
    @(negedge clk); g0 = gap_q.size();
    @(posedge clk); #1;
    send_frame(2, 8'h30, 4'hF);
    send_frame(2, 8'h40, 4'hF);
    wait_frames(d0 + 3, pk);
    checks++; if (pk != 2) begin errors++; $display("FAIL b2b_pkts_peak: got %0d want 2", pk); end
    checks++;
    if (gap_q.size() - g0 < 2) begin errors++; $display("FAIL b2b_gap_count: got %0d want 2", gap_q.size() - g0); end
    else begin
      checks++; if (gap_q[g0] != IFG + 1) begin errors++; $display("FAIL b2b_gap1: got %0d want %0d", gap_q[g0], IFG + 1); end
      checks++; if (gap_q[g0+1] != IFG + 1) begin errors++; $display("FAIL b2b_gap2: got %0d want %0d", gap_q[g0+1], IFG + 1); end
    end
    n = byte_q.size() - s;
    checks++; if (n != 24) begin errors++; $display("FAIL b2b_len: got %0d want 24", n); end
    bad = 0;
    for (int i = 0; i < n && i < 24; i++) begin
      e = 8'h20 + 8'((i / 8) * 16 + (i % 8));
      if (byte_q[s+i] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data: %0d wrong bytes, want 0", bad); end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_oversize;
    int s, d0, dr0, n, bad, pk;
    ack_mode = 2; s = byte_q.size(); d0 = done_cnt; dr0 = drop_cnt;
    send_frame(20, 8'h50, 4'hF);
    @(negedge clk);
    checks++; if (oversize_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", oversize_drop); end
    checks++; if (pkts_queued !== 3'd0) begin errors++; $display("FAIL drop_no_pkt: got %0d want 0", pkts_queued); end
    @(negedge clk);
    checks++; if (oversize_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %b want 0", oversize_drop); end
    @(posedge clk); #1;
    send_frame(4, 8'hC0, 4'hF);
    wait_frames(d0 + 1, pk);
    repeat (4) @(negedge clk);
    n = byte_q.size() - s;
    checks++; if (n != 16) begin errors++; $display("FAIL drop_next_len: got %0d want 16", n); end
    bad = 0;
    for (int i = 0; i < n && i < 16; i++) if (byte_q[s+i] !== 8'hC0 + 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_next_data: %0d wrong bytes, want 0", bad); end
    checks++; if (drop_cnt - dr0 != 1) begin errors++; $display("FAIL drop_count: got %0d want 1", drop_cnt - dr0); end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // First frame sits in WAIT_ACK (no longer counted), four more fill the limit.
  task automatic test_max_pkts;
    int s, d0, n, bad, pk;
    logic [7:0] e;
    ack_mode = 0; s = byte_q.size(); d0 = done_cnt;
    for (int f = 0; f < 5; f++) send_frame(1, 8'h60 + 8'(f*16), 4'hF);
    repeat (2) @(negedge clk);
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL maxp_tready: got %b want 0", tready); end
    checks++; if (pkts_queued !== 3'd4) begin errors++; $display("FAIL maxp_pkts: got %0d want 4", pkts_queued); end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_data_valid !== 1'b1 || tx_data !== 8'h60 || tready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL maxp_byte0_stable: %0d bad cycles, want 0", bad); end
    checks++; if (byte_q.size() != s) begin errors++; $display("FAIL maxp_no_consume: got %0d bytes want 0", byte_q.size() - s); end
    ack_mode = 2;
    wait_frames(d0 + 5, pk);
    n = byte_q.size() - s;
    checks++; if (n != 20) begin errors++; $display("FAIL maxp_len: got %0d want 20", n); end
    bad = 0;
    for (int i = 0; i < n && i < 20; i++) begin
      e = 8'h60 + 8'((i / 4) * 16 + (i % 4));
      if (byte_q[s+i] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL maxp_data: %0d wrong bytes, want 0", bad); end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int s, d0, n, bad, pk;
    ack_mode = 1;
    send_frame(16, 8'h00, 4'hF);
    wait_valid("rst_first_valid");
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", tready); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_drop: got %b want 0", tx_data_valid); end
    checks++; if (pkts_queued !== 3'd0) begin errors++; $display("FAIL rst_pkts: got %0d want 0", pkts_queued); end
    @(posedge clk); #1;
    s = byte_q.size(); d0 = done_cnt;
    send_frame(2, 8'hE0, 4'h7);
    wait_frames(d0 + 1, pk);
    n = byte_q.size() - s;
    checks++; if (n != 7) begin errors++; $display("FAIL rst_new_len: got %0d want 7", n); end
    bad = 0;
    for (int i = 0; i < n && i < 7; i++) if (byte_q[s+i] !== 8'hE0 + 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_new_data: %0d wrong bytes, want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_partial_last;
    test_strb_edges;
    test_back_to_back;
    test_oversize;
    test_max_pkts;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
